vga_timing_gen: RTL

- Raster timing generator for the VGA path. Runs in the 25.175 MHz pixel-clock domain (PLL outclk_0) and consumes the PLL locked output.
- Produces hsync/vsync, the active-video flag and pixel coordinates for 640x480@60.
- Issues a per-line fetch request/ack handshake so the downstream line buffer is loaded one line ahead.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_timing_gen_lock_sync.sv | 24 ++
 rtl/vga_timing_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 raster timing generator.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam logic        VGA_SYNC_POL = 1'b0;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_e;

endpackage

// File: rtl/vga_timing_gen_lock_sync.sv
// Generic two-flop synchronizer, asynchronous active-high reset to 0.
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with one-line-ahead fetch handshake.
// Optional frame_count output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = VGA_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start,
    output logic               line_req,
    output logic [COORD_W-1:0] line_num,
    input  logic               line_ack,
    output logic               underrun
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] H_LAST_C = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] HS_BEG_C = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END_C = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_LAST_C = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] VS_BEG_C = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END_C = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic               lock_s;
    vga_state_e         state_q, state_d;
    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic [COORD_W-1:0] pixel_x_q, pixel_x_d;
    logic [COORD_W-1:0] pixel_y_q, pixel_y_d;
    logic               frame_start_q, frame_start_d;
    logic               line_req_q, line_req_d;
    logic [COORD_W-1:0] line_num_q, line_num_d;
    logic               underrun_q, underrun_d;
    logic               run_c;
    logic [COORD_W-1:0] next_line_c;

    lock_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Losing lock mid-frame takes effect in the same cycle it is seen.
    assign run_c       = (state_q == RUN) && lock_s;
    assign next_line_c = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + COORD_W'(1);

    always_comb begin
        state_d       = state_q;
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        active_d      = 1'b0;
        pixel_x_d     = '0;
        pixel_y_d     = '0;
        frame_start_d = 1'b0;
        line_req_d    = 1'b0;
        line_num_d    = '0;
        underrun_d    = underrun_q;

        case (state_q)
            WAIT_LOCK: if (lock_s)  state_d = RUN;
            RUN:       if (!lock_s) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase

        if (run_c) begin
            if (h_cnt_q == H_LAST_C) begin
                h_cnt_d = '0;
                v_cnt_d = next_line_c;
            end else begin
                h_cnt_d = h_cnt_q + COORD_W'(1);
                v_cnt_d = v_cnt_q;
            end

            active_d      = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
            pixel_x_d     = active_d ? h_cnt_q : '0;
            pixel_y_d     = active_d ? v_cnt_q : '0;
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            if ((h_cnt_q >= HS_BEG_C) && (h_cnt_q <= HS_END_C)) hsync_d = SYNC_POL;
            if ((v_cnt_q >= VS_BEG_C) && (v_cnt_q <= VS_END_C)) vsync_d = SYNC_POL;

            // Ack wins over the end-of-line deadline when both land together.
            line_req_d = line_req_q;
            line_num_d = line_num_q;
            if (line_req_q) begin
                if (line_ack) begin
                    line_req_d = 1'b0;
                end else if (h_cnt_q == H_LAST_C) begin
                    line_req_d = 1'b0;
                    underrun_d = 1'b1;
                end
            end
            if ((h_cnt_q == H_ACT_C) && (next_line_c < V_ACT_C)) begin
                line_req_d = 1'b1;
                line_num_d = next_line_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
            line_req_q    <= 1'b0;
            line_num_q    <= '0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
            line_req_q    <= line_req_d;
            line_num_q    <= line_num_d;
            underrun_q    <= underrun_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;
    assign line_req    = line_req_q;
    assign line_num    = line_num_q;
    assign underrun    = underrun_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    // Advances on the same edge that raises frame_start; holds while unlocked.
    always_comb begin
        frame_count_d = frame_count_q + FRAME_CNT_W'(frame_start_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_count_q <= '0;
        else     frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`endif

endmodule
